// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
//   state_t : controller states (IDLE, RUN, PAUSE)
//   BCD_W   : width of one decade
//   BCD_MAX : last legal value of a decade before it rolls to 0
package bcd_stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int              BCD_W   = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// One BCD decade counter.
//   Clk      : system clock
//   Reset_n  : asynchronous active-low reset
//   Clr      : synchronous clear, wins over Inc
//   Inc      : count enable for this decade
//   Q        : decade value, always 0..9
//   CarryOut : Inc while at 9, feeds the next decade in the same cycle
module bcd_digit
   import bcd_stopwatch_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Clr,
   input  logic             Inc,
   output logic [BCD_W-1:0] Q,
   output logic             CarryOut
);

   assign CarryOut = Inc & (Q == BCD_MAX);

   // The >= compare also folds any out-of-range value back to 0.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Q <= '0;
      end else if (Clr) begin
         Q <= '0;
      end else if (Inc) begin
         Q <= (Q >= BCD_MAX) ? '0 : Q + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_stopwatch.sv
// BCD stopwatch driven by the divider's slow square wave, sampled as data.
//   Clk       : system clock
//   Reset_n   : asynchronous active-low reset
//   SlowClk   : divider output, asynchronous level
//   StartStop : rising edge toggles run/pause
//   Clear     : level, forces IDLE and a zero count
//   Digits    : BCD count, digit 0 in [3:0]
//   Running   : high while in RUN
//   Tick      : one-cycle pulse per SlowClk rising edge
//   Wrap      : one-cycle pulse when the count rolls from all 9s to 0
//
// state | meaning
// IDLE  | stopped after reset or Clear, count is zero
// RUN   | ticks advance the count
// PAUSE | count held, ticks ignored
module bcd_stopwatch
   import bcd_stopwatch_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic                        Clk,
   input  logic                        Reset_n,
   input  logic                        SlowClk,
   input  logic                        StartStop,
   input  logic                        Clear,
   output logic [BCD_W*NUM_DIGITS-1:0] Digits,
   output logic                        Running,
   output logic                        Tick,
   output logic                        Wrap
);

   logic            s1, s2, s3;
   logic            tick_int;
   logic            ss_q;
   logic            ss_edge;
   state_t          state;
   logic [NUM_DIGITS:0] carry;

   assign tick_int = s2 & ~s3;
   assign ss_edge  = StartStop & ~ss_q;

   // Increment judged against the current state, so a tick coinciding with
   // RUN->PAUSE still counts and one coinciding with ->RUN does not.
   assign carry[0] = Tick & (state == RUN) & ~Clear;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .Clk      (Clk),
         .Reset_n  (Reset_n),
         .Clr      (Clear),
         .Inc      (carry[i]),
         .Q        (Digits[i*BCD_W +: BCD_W]),
         .CarryOut (carry[i+1])
      );
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         Tick <= 1'b0;
         ss_q <= 1'b0;
         Wrap <= 1'b0;
      end else begin
         s1   <= SlowClk;
         s2   <= s1;
         s3   <= s2;
         Tick <= tick_int;
         ss_q <= StartStop;
         Wrap <= carry[NUM_DIGITS];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= IDLE;
         Running <= 1'b0;
      end else if (Clear) begin
         state   <= IDLE;
         Running <= 1'b0;
      end else if (ss_edge) begin
         case (state)
            IDLE, PAUSE: begin
               state   <= RUN;
               Running <= 1'b1;
            end
            RUN: begin
               state   <= PAUSE;
               Running <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               Running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch.sv
module tb_bcd_stopwatch;

   localparam int ND = 4;

   logic          Clk       = 1'b0;
   logic          Reset_n   = 1'b0;
   logic          SlowClk   = 1'b0;
   logic          StartStop = 1'b0;
   logic          Clear     = 1'b0;
   logic [4*ND-1:0] Digits;
   logic          Running;
   logic          Tick;
   logic          Wrap;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 Clk = ~Clk;

   bcd_stopwatch #(.NUM_DIGITS(ND)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .SlowClk   (SlowClk),
      .StartStop (StartStop),
      .Clear     (Clear),
      .Digits    (Digits),
      .Running   (Running),
      .Tick      (Tick),
      .Wrap      (Wrap)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One slow period of 8 cycles, counting Tick-high samples.
   task automatic slow_pulse(output int ticks);
      ticks   = 0;
      SlowClk = 1'b1;
      repeat (4) begin
         @(negedge Clk);
         if (Tick) ticks++;
      end
      SlowClk = 1'b0;
      repeat (4) begin
         @(negedge Clk);
         if (Tick) ticks++;
      end
   endtask

   task automatic fast_ticks(input int n);
      repeat (n) begin
         SlowClk = 1'b1;
         repeat (2) @(negedge Clk);
         SlowClk = 1'b0;
         repeat (2) @(negedge Clk);
      end
      repeat (6) @(negedge Clk);
   endtask

   task automatic ss_pulse();
      StartStop = 1'b1;
      @(negedge Clk);
      StartStop = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      n_checks++; if (Digits !== 16'h0000) $display("FAIL reset_digits: got %h expected 0000", Digits); else n_pass++;
      n_checks++; if (Running !== 1'b0) $display("FAIL reset_running: got %b expected 0", Running); else n_pass++;
      n_checks++; if (Tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", Tick); else n_pass++;
      n_checks++; if (Wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", Wrap); else n_pass++;
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_idle_ticks();
      int t;
      for (int i = 0; i < 3; i++) begin
         slow_pulse(t);
         n_checks++; if (t !== 1) $display("FAIL idle_tick_width[%0d]: got %0d high cycles expected 1", i, t); else n_pass++;
      end
      n_checks++; if (Digits !== 16'h0000) $display("FAIL idle_digits: got %h expected 0000", Digits); else n_pass++;
      n_checks++; if (Running !== 1'b0) $display("FAIL idle_running: got %b expected 0", Running); else n_pass++;
   endtask

   task automatic test_count();
      int t;
      ss_pulse();
      n_checks++; if (Running !== 1'b1) $display("FAIL count_running: got %b expected 1", Running); else n_pass++;
      repeat (12) slow_pulse(t);
      n_checks++; if (Digits !== 16'h0012) $display("FAIL count_12: got %h expected 0012", Digits); else n_pass++;
   endtask

   task automatic test_pause();
      int t;
      ss_pulse();
      n_checks++; if (Running !== 1'b0) $display("FAIL pause_running: got %b expected 0", Running); else n_pass++;
      repeat (5) slow_pulse(t);
      n_checks++; if (Digits !== 16'h0012) $display("FAIL pause_hold: got %h expected 0012", Digits); else n_pass++;
      ss_pulse();
      n_checks++; if (Running !== 1'b1) $display("FAIL resume_running: got %b expected 1", Running); else n_pass++;
      repeat (3) slow_pulse(t);
      n_checks++; if (Digits !== 16'h0015) $display("FAIL resume_count: got %h expected 0015", Digits); else n_pass++;
   endtask

   task automatic test_wrap();
      int t;
      int wraps;
      logic [15:0] wrap_dig;
      Clear = 1'b1;
      @(negedge Clk);
      Clear = 1'b0;
      @(negedge Clk);
      n_checks++; if (Digits !== 16'h0000) $display("FAIL clear_digits: got %h expected 0000", Digits); else n_pass++;
      n_checks++; if (Running !== 1'b0) $display("FAIL clear_running: got %b expected 0", Running); else n_pass++;
      ss_pulse();
      fast_ticks(9998);
      n_checks++; if (Digits !== 16'h9998) $display("FAIL preload_9998: got %h expected 9998", Digits); else n_pass++;
      slow_pulse(t);
      n_checks++; if (Digits !== 16'h9999) $display("FAIL count_9999: got %h expected 9999", Digits); else n_pass++;
      wraps    = 0;
      wrap_dig = 16'hFFFF;
      SlowClk  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) SlowClk = 1'b0;
         @(negedge Clk);
         if (Wrap) begin
            wraps++;
            wrap_dig = Digits;
         end
      end
      n_checks++; if (wraps !== 1) $display("FAIL wrap_width: got %0d high cycles expected 1", wraps); else n_pass++;
      n_checks++; if (wrap_dig !== 16'h0000) $display("FAIL wrap_digits: got %h expected 0000", wrap_dig); else n_pass++;
      n_checks++; if (Running !== 1'b1) $display("FAIL wrap_running: got %b expected 1", Running); else n_pass++;
   endtask

   task automatic test_clear_collision();
      SlowClk = 1'b1;
      repeat (3) @(negedge Clk);
      n_checks++; if (Tick !== 1'b1) $display("FAIL collide_tick: got %b expected 1", Tick); else n_pass++;
      StartStop = 1'b1;
      Clear     = 1'b1;
      @(negedge Clk);
      n_checks++; if (Digits !== 16'h0000) $display("FAIL collide_digits: got %h expected 0000", Digits); else n_pass++;
      n_checks++; if (Running !== 1'b0) $display("FAIL collide_running: got %b expected 0", Running); else n_pass++;
      StartStop = 1'b0;
      @(negedge Clk);
      Clear   = 1'b0;
      SlowClk = 1'b0;
      repeat (4) @(negedge Clk);
      n_checks++; if (Running !== 1'b0) $display("FAIL collide_idle: got %b expected 0", Running); else n_pass++;
      n_checks++; if (Digits !== 16'h0000) $display("FAIL collide_hold: got %h expected 0000", Digits); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int cnt;
      int pos;
      ss_pulse();
      n_checks++; if (Running !== 1'b1) $display("FAIL mid_running: got %b expected 1", Running); else n_pass++;
      fast_ticks(347);
      n_checks++; if (Digits !== 16'h0347) $display("FAIL mid_0347: got %h expected 0347", Digits); else n_pass++;
      SlowClk = 1'b1;
      repeat (3) @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      n_checks++; if (Digits !== 16'h0000) $display("FAIL async_digits: got %h expected 0000", Digits); else n_pass++;
      n_checks++; if (Running !== 1'b0) $display("FAIL async_running: got %b expected 0", Running); else n_pass++;
      n_checks++; if (Tick !== 1'b0) $display("FAIL async_tick: got %b expected 0", Tick); else n_pass++;
      n_checks++; if (Wrap !== 1'b0) $display("FAIL async_wrap: got %b expected 0", Wrap); else n_pass++;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      cnt = 0;
      pos = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge Clk);
         if (Tick) begin
            cnt++;
            pos = k;
         end
      end
      n_checks++; if (cnt !== 1) $display("FAIL release_tick_count: got %0d expected 1", cnt); else n_pass++;
      n_checks++; if (pos !== 3) $display("FAIL release_tick_latency: got edge %0d expected 3", pos); else n_pass++;
      SlowClk = 1'b0;
      repeat (2) @(negedge Clk);
      n_checks++; if (Digits !== 16'h0000) $display("FAIL release_digits: got %h expected 0000", Digits); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_idle_ticks();
      test_count();
      test_pause();
      test_wrap();
      test_clear_collision();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
